// File: rtl/riscv_issue_scheduler.sv
`default_nettype none
// riscv_issue_scheduler -- in-order issue gate with long-latency scoreboard and divider busy tracking.
// Second-way issue is built only when RISCV_DUAL_ISSUE_EN is defined.  Rev 1.0

`ifndef UNIT_NUM
`define UNIT_NUM 6
`endif
`ifndef RD_USE
`define RD_USE 0
`endif
`ifndef LSU_USE
`define LSU_USE 1
`endif
`ifndef MUL_USE
`define MUL_USE 2
`endif
`ifndef DIV_USE
`define DIV_USE 3
`endif
`ifndef CSR_USE
`define CSR_USE 4
`endif
`ifndef BRANCH_USE
`define BRANCH_USE 5
`endif

module riscv_issue_scheduler #(
  parameter int DIV_LATENCY = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_occur,
  input  logic                 exec_ready,
  input  logic                 way0_valid,
  input  logic                 way1_valid,
  input  logic [31:0]          way0_inst,
  input  logic [31:0]          way1_inst,
  input  logic [`UNIT_NUM-1:0] way0_unit_usage,
  input  logic [`UNIT_NUM-1:0] way1_unit_usage,
  input  logic                 lwb_valid,
  input  logic [4:0]           lwb_rd,
  output logic                 way0_inst_been_accepted,
  output logic                 way1_inst_been_accepted,
  output logic                 div_busy,
  output logic                 sb_busy
);

  localparam logic [5:0] C_DIV_LOAD = 6'(DIV_LATENCY - 1);

  logic [31:1] sb_q, sb_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [31:0] w_sb;
  logic [31:0] w_set, w_clr;

  // Bit 0 is a constant zero so x0 lookups never report a hazard.
  assign w_sb = {sb_q, 1'b0};

  logic [4:0] w_rs1_0, w_rs2_0, w_rd_0;
  logic       w_hz0, w_long0, w_div0, w_csr0, w_grant0;

  assign w_rs1_0 = way0_inst[19:15];
  assign w_rs2_0 = way0_inst[24:20];
  assign w_rd_0  = way0_inst[11:7];
  assign w_hz0   = w_sb[w_rs1_0] | w_sb[w_rs2_0] | w_sb[w_rd_0];
  assign w_div0  = way0_unit_usage[`DIV_USE];
  assign w_csr0  = way0_unit_usage[`CSR_USE];
  assign w_long0 = way0_unit_usage[`RD_USE] && (w_rd_0 != 5'd0) &&
                   (way0_unit_usage[`LSU_USE] | way0_unit_usage[`MUL_USE] | w_div0);

  assign w_grant0 = !rst && way0_valid && exec_ready && !branch_occur && !w_hz0 &&
                    !(w_div0 && div_busy) && !(w_csr0 && sb_busy);

  logic w_grant1;
  logic w_div_issue;
  logic w_unused;

`ifdef RISCV_DUAL_ISSUE_EN
  logic [4:0] w_rs1_1, w_rs2_1, w_rd_1;
  logic       w_hz1, w_long1, w_struct, w_dep;

  assign w_rs1_1 = way1_inst[19:15];
  assign w_rs2_1 = way1_inst[24:20];
  assign w_rd_1  = way1_inst[11:7];
  assign w_hz1   = w_sb[w_rs1_1] | w_sb[w_rs2_1] | w_sb[w_rd_1];
  assign w_long1 = way1_unit_usage[`RD_USE] && (w_rd_1 != 5'd0) &&
                   (way1_unit_usage[`LSU_USE] | way1_unit_usage[`MUL_USE] |
                    way1_unit_usage[`DIV_USE]);

  assign w_struct = (way0_unit_usage[`LSU_USE]    && way1_unit_usage[`LSU_USE]) ||
                    (way0_unit_usage[`BRANCH_USE] && way1_unit_usage[`BRANCH_USE]) ||
                    (way0_unit_usage[`MUL_USE]    && way1_unit_usage[`MUL_USE]) ||
                    (w_div0                       && way1_unit_usage[`DIV_USE]) ||
                    w_csr0 || way1_unit_usage[`CSR_USE];

  assign w_dep = way0_unit_usage[`RD_USE] && (w_rd_0 != 5'd0) &&
                 ((w_rs1_1 == w_rd_0) || (w_rs2_1 == w_rd_0) || (w_rd_1 == w_rd_0));

  // A divide in way1 must also wait for the shared divider to drain.
  assign w_grant1 = w_grant0 && way1_valid && !w_hz1 && !w_struct &&
                    !way0_unit_usage[`BRANCH_USE] && !w_dep &&
                    !(way1_unit_usage[`DIV_USE] && div_busy);

  assign w_set = ((w_grant0 && w_long0) ? (32'd1 << w_rd_0) : 32'd0) |
                 ((w_grant1 && w_long1) ? (32'd1 << w_rd_1) : 32'd0);
  assign w_div_issue = (w_grant0 && w_div0) || (w_grant1 && way1_unit_usage[`DIV_USE]);
  assign w_unused = ^{way0_inst[31:25], way0_inst[14:12], way0_inst[6:0],
                      way1_inst[31:25], way1_inst[14:12], way1_inst[6:0],
                      w_set[0], w_clr[0]};
`else
  assign w_grant1    = 1'b0;
  assign w_set       = (w_grant0 && w_long0) ? (32'd1 << w_rd_0) : 32'd0;
  assign w_div_issue = w_grant0 && w_div0;
  assign w_unused = ^{way0_inst[31:25], way0_inst[14:12], way0_inst[6:0],
                      way1_valid, way1_inst, way1_unit_usage, w_set[0], w_clr[0]};
`endif

  // Set is applied after clear so a same-cycle issue to the released register wins.
  assign w_clr = lwb_valid ? (32'd1 << lwb_rd) : 32'd0;
  assign sb_d  = (sb_q & ~w_clr[31:1]) | w_set[31:1];

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (w_div_issue) begin
      div_cnt_d = C_DIV_LOAD;
    end else if (div_cnt_q != 6'd0) begin
      div_cnt_d = div_cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q      <= '0;
      div_cnt_q <= '0;
    end else begin
      sb_q      <= sb_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign way0_inst_been_accepted = w_grant0;
  assign way1_inst_been_accepted = w_grant1;
  assign div_busy                = (div_cnt_q != 6'd0);
  assign sb_busy                 = |sb_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_issue_scheduler.sv
`default_nettype none
// tb_riscv_issue_scheduler -- directed vectors with a queued expectation scoreboard.

`ifndef UNIT_NUM
`define UNIT_NUM 6
`endif
`ifndef RD_USE
`define RD_USE 0
`endif
`ifndef LSU_USE
`define LSU_USE 1
`endif
`ifndef MUL_USE
`define MUL_USE 2
`endif
`ifndef DIV_USE
`define DIV_USE 3
`endif
`ifndef CSR_USE
`define CSR_USE 4
`endif
`ifndef BRANCH_USE
`define BRANCH_USE 5
`endif

module tb_riscv_issue_scheduler;

`ifdef RISCV_DUAL_ISSUE_EN
  localparam logic DUAL = 1'b1;
`else
  localparam logic DUAL = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 branch_occur, exec_ready;
  logic                 way0_valid, way1_valid;
  logic [31:0]          way0_inst, way1_inst;
  logic [`UNIT_NUM-1:0] way0_unit_usage, way1_unit_usage;
  logic                 lwb_valid;
  logic [4:0]           lwb_rd;
  logic                 way0_inst_been_accepted, way1_inst_been_accepted;
  logic                 div_busy, sb_busy;

  riscv_issue_scheduler #(.DIV_LATENCY(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .branch_occur            (branch_occur),
    .exec_ready              (exec_ready),
    .way0_valid              (way0_valid),
    .way1_valid              (way1_valid),
    .way0_inst               (way0_inst),
    .way1_inst               (way1_inst),
    .way0_unit_usage         (way0_unit_usage),
    .way1_unit_usage         (way1_unit_usage),
    .lwb_valid               (lwb_valid),
    .lwb_rd                  (lwb_rd),
    .way0_inst_been_accepted (way0_inst_been_accepted),
    .way1_inst_been_accepted (way1_inst_been_accepted),
    .div_busy                (div_busy),
    .sb_busy                 (sb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  g0, g1, db, sb;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [`UNIT_NUM-1:0] um(input logic rd, lsu, mul, dv, csr, br);
    logic [`UNIT_NUM-1:0] u;
    u = '0;
    u[`RD_USE]     = rd;
    u[`LSU_USE]    = lsu;
    u[`MUL_USE]    = mul;
    u[`DIV_USE]    = dv;
    u[`CSR_USE]    = csr;
    u[`BRANCH_USE] = br;
    return u;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs1, rs2, input logic [6:0] f7);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] ld(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic check(input string name, input string sig, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s got %0b expected %0b", name, sig, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "way0_grant", way0_inst_been_accepted, e.g0);
        check(e.name, "way1_grant", way1_inst_been_accepted, e.g1);
        check(e.name, "div_busy",   div_busy,                e.db);
        check(e.name, "sb_busy",    sb_busy,                 e.sb);
      end
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
    rst             = 1'b0;
    branch_occur    = 1'b0;
    exec_ready      = 1'b1;
    way0_valid      = 1'b0;
    way1_valid      = 1'b0;
    way0_inst       = 32'd0;
    way1_inst       = 32'd0;
    way0_unit_usage = '0;
    way1_unit_usage = '0;
    lwb_valid       = 1'b0;
    lwb_rd          = 5'd0;
  endtask

  task automatic w0(input logic [31:0] inst, input logic [`UNIT_NUM-1:0] u);
    way0_valid = 1'b1; way0_inst = inst; way0_unit_usage = u;
  endtask

  task automatic w1(input logic [31:0] inst, input logic [`UNIT_NUM-1:0] u);
    way1_valid = 1'b1; way1_inst = inst; way1_unit_usage = u;
  endtask

  task automatic lwb(input logic [4:0] rd);
    lwb_valid = 1'b1; lwb_rd = rd;
  endtask

  task automatic ex(input string name, input logic g0, g1, db, sb);
    exp_t e;
    e.name = name; e.g0 = g0; e.g1 = g1; e.db = db; e.sb = sb;
    exp_q.push_back(e);
  endtask

  logic [`UNIT_NUM-1:0] U_ALU, U_LD, U_MUL, U_DIV, U_CSR, U_BR;
  logic [31:0]          BEQ, CSRW;

  initial begin
    U_ALU = um(1, 0, 0, 0, 0, 0);
    U_LD  = um(1, 1, 0, 0, 0, 0);
    U_MUL = um(1, 0, 1, 0, 0, 0);
    U_DIV = um(1, 0, 0, 1, 0, 0);
    U_CSR = um(1, 0, 0, 0, 1, 0);
    U_BR  = um(0, 0, 0, 0, 0, 1);
    BEQ   = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    CSRW  = {12'h340, 5'd0, 3'b001, 5'd14, 7'b1110011};

    rst = 1'b1; branch_occur = 1'b0; exec_ready = 1'b1;
    way0_valid = 1'b0; way1_valid = 1'b0; way0_inst = '0; way1_inst = '0;
    way0_unit_usage = '0; way1_unit_usage = '0; lwb_valid = 1'b0; lwb_rd = '0;

    nx(); rst = 1'b1; w0(rtype(3, 1, 2, 0), U_ALU); ex("reset_hold", 0, 0, 0, 0);
    nx(); w0(rtype(3, 1, 2, 0), U_ALU); w1(rtype(5, 4, 6, 0), U_ALU); ex("dual_alu", 1, DUAL, 0, 0);
    nx(); w0(rtype(3, 1, 2, 0), U_ALU); w1(rtype(4, 3, 1, 7'h20), U_ALU); ex("raw_pair", 1, 0, 0, 0);
    nx(); w0(rtype(4, 3, 1, 7'h20), U_ALU); ex("raw_next", 1, 0, 0, 0);
    nx(); w0(ld(7, 1), U_LD); w1(rtype(11, 12, 13, 0), U_ALU); ex("lw_issue", 1, DUAL, 0, 0);
    nx(); w0(rtype(8, 7, 0, 0), U_ALU); ex("lw_use_stall", 0, 0, 0, 1);
    nx(); w0(rtype(8, 7, 0, 0), U_ALU); lwb(7); ex("lwb_no_bypass", 0, 0, 0, 1);
    nx(); w0(rtype(8, 7, 0, 0), U_ALU); ex("lw_use_go", 1, 0, 0, 0);
    nx(); w0(rtype(9, 1, 2, 7'h01), U_DIV); ex("div_issue", 1, 0, 0, 0);
    nx(); w0(rtype(10, 1, 2, 7'h01), U_DIV); ex("div_busy1", 0, 0, 1, 1);
    nx(); w0(rtype(10, 1, 2, 7'h01), U_DIV); ex("div_busy2", 0, 0, 1, 1);
    nx(); w0(rtype(10, 1, 2, 7'h01), U_DIV); ex("div_busy3", 0, 0, 1, 1);
    nx(); w0(rtype(10, 1, 2, 7'h01), U_DIV); ex("div_second", 1, 0, 0, 1);
    nx(); lwb(9); ex("div_drain1", 0, 0, 1, 1);
    nx(); lwb(10); ex("div_drain2", 0, 0, 1, 1);
    nx(); w0(rtype(10, 1, 2, 7'h01), U_MUL); ex("mul_issue", 1, 0, 1, 0);
    nx(); branch_occur = 1'b1; w0(rtype(3, 1, 2, 0), U_ALU); w1(rtype(5, 4, 6, 0), U_ALU);
    ex("branch_flush", 0, 0, 0, 1);
    nx(); w0(rtype(11, 10, 1, 0), U_ALU); lwb(10); ex("mul_kept", 0, 0, 0, 1);
    nx(); w0(rtype(11, 10, 1, 0), U_ALU); ex("mul_release", 1, 0, 0, 0);
    nx(); w0(ld(0, 1), U_LD); ex("x0_load", 1, 0, 0, 0);
    nx(); w0(rtype(1, 0, 0, 0), U_ALU); ex("x0_unmarked", 1, 0, 0, 0);
    nx(); w0(ld(12, 1), U_LD); lwb(12); ex("set_clr_same", 1, 0, 0, 0);
    nx(); lwb(12); ex("set_wins", 0, 0, 0, 1);
    nx(); w0(ld(13, 1), U_LD); ex("lw13", 1, 0, 0, 0);
    nx(); w0(CSRW, U_CSR); lwb(13); ex("csr_wait", 0, 0, 0, 1);
    nx(); w0(CSRW, U_CSR); ex("csr_go", 1, 0, 0, 0);
    nx(); exec_ready = 1'b0; w0(rtype(3, 1, 2, 0), U_ALU); ex("exec_stall", 0, 0, 0, 0);
    nx(); w0(BEQ, U_BR); w1(rtype(5, 4, 6, 0), U_ALU); ex("branch_way0", 1, 0, 0, 0);
    nx(); w0(ld(15, 1), U_LD); w1(ld(16, 2), U_LD); ex("both_lsu", 1, 0, 0, 0);
    nx(); w0(rtype(17, 1, 2, 0), U_ALU); w1(rtype(18, 15, 1, 0), U_ALU); lwb(15);
    ex("way1_sb_hit", 1, 0, 0, 1);
    nx(); w0(rtype(21, 2, 3, 0), U_ALU); w1(ld(20, 1), U_LD); ex("way1_load", 1, DUAL, 0, 0);
    nx(); lwb(20); ex("way1_mark", 0, 0, 0, DUAL);
    nx(); w0(rtype(22, 1, 2, 7'h01), U_DIV); ex("pre_rst_div", 1, 0, 0, 0);
    nx(); w0(ld(7, 1), U_LD); ex("pre_rst_lw7", 1, 0, 1, 1);
    nx(); w0(ld(9, 1), U_LD); ex("pre_rst_lw9", 1, 0, 1, 1);
    nx(); rst = 1'b1; w0(rtype(3, 1, 2, 0), U_ALU); ex("async_rst", 0, 0, 0, 0);
    nx(); ex("post_rst_idle", 0, 0, 0, 0);
    nx(); w0(rtype(7, 9, 1, 0), U_ALU); ex("post_rst_issue", 1, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_issue_scheduler.md
RISCV_ISSUE_SCHEDULER -- requirements
Module: riscv_issue_scheduler

Interface
REQ-001 The block SHALL have parameter DIV_LATENCY, default 33, meaning cycles the iterative divider stays occupied per DIV issue (legal range 2..63).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port branch_occur  input  1  pipeline flush.
REQ-005 The block SHALL have port exec_ready  input  1  execute stage can accept this cycle.
REQ-006 The block SHALL have ports way0_valid / way1_valid  input  1  queue head entries valid.
REQ-007 The block SHALL have ports way0_inst / way1_inst  input  32  head instructions.
REQ-008 The block SHALL have ports way0_unit_usage / way1_unit_usage  input  `UNIT_NUM  usage vectors, indexed by the `*_USE bit macros.
REQ-009 The block SHALL have ports lwb_valid  input  1, lwb_rd  input  5  long-latency writeback that releases a scoreboard entry.
REQ-010 The block SHALL have ports way0_inst_been_accepted / way1_inst_been_accepted  output  1  issue grants, which are also the queue pops.
REQ-011 The block SHALL have ports div_busy  output  1, sb_busy  output  1  divider occupied / any scoreboard bit set.

Function
REQ-012 Fields SHALL be rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7]; both rs fields are always compared regardless of format.
REQ-013 Register x0 SHALL never cause a hazard and SHALL never be marked.
REQ-014 Scoreboard SHALL be 31 registered bits (x1..x31); a bit is set when an issuing way has RD_USE and one of LSU_USE, MUL_USE or DIV_USE, and rd!=0.
REQ-015 A scoreboard bit SHALL clear on lwb_valid for lwb_rd; when set and clear target the same register in the same cycle, set wins.
REQ-016 Hazard checks SHALL use the registered scoreboard only (no clear bypass), so a register becomes usable the cycle after its lwb.
REQ-017 way0 SHALL be granted iff way0_valid, exec_ready, !branch_occur, no scoreboard hit on rs1/rs2/rd, !(DIV_USE && div_busy), and !(CSR_USE && sb_busy).
REQ-018 way1 SHALL be granted only if way0 is granted in the same cycle (in-order issue).
REQ-019 way1 SHALL additionally require way1_valid and no scoreboard hit on its rs1/rs2/rd.
REQ-020 way1 SHALL additionally require no structural conflict: not both LSU, not both BRANCH, not both MUL, not both DIV, and neither way CSR.
REQ-021 way1 SHALL additionally require that way0 has no BRANCH_USE.
REQ-022 way1 SHALL additionally require no RAW/WAW with way0: when way0 has RD_USE and rd0!=0, each of way1 rs1, rs2 and rd must differ from rd0.
REQ-023 Grants SHALL be combinational from inputs and registered state; the queue pops in the same cycle.
REQ-024 The div counter SHALL be 6 bits, loaded with DIV_LATENCY-1 on a DIV grant (either way) and decremented to 0 otherwise; div_busy = (counter != 0).
REQ-025 branch_occur SHALL suppress both grants in its cycle; the scoreboard and div counter SHALL be unaffected, since in-flight operations still write back.
REQ-026 sb_busy SHALL be the OR of all scoreboard bits (registered state).

Reset
REQ-027 While rst is high, the scoreboard SHALL be 0, the div counter 0, and both grants forced to 0.
REQ-028 Deasserting rst mid-divide SHALL leave the block idle: div_busy=0 and no pending entries.

Configuration
REQ-029 Macro RISCV_DUAL_ISSUE_EN defined: way1 SHALL follow REQ-018..REQ-022.
REQ-030 RISCV_DUAL_ISSUE_EN undefined: way1_inst_been_accepted SHALL be tied to 0, and way1 inputs SHALL not affect any state.

Verification
REQ-031 way0 "add x3,x1,x2" and way1 "add x5,x4,x6", both valid, exec_ready=1 -> both grants =1 in the same cycle.
REQ-032 way0 "lw x7,0(x1)" granted; next cycle way0 "add x8,x7,x0" -> stalled until the cycle after lwb_valid=1 with lwb_rd=7, then granted.
REQ-033 way0 "div x9,x1,x2" granted with DIV_LATENCY=4 -> div_busy high for 3 cycles; a second div is granted on the 4th cycle after the first issue.
REQ-034 way0 "add x3,x1,x2" and way1 "sub x4,x3,x1" -> way0=1, way1=0; next cycle way1's entry, now at way0, is granted.
REQ-035 branch_occur=1 with both ways valid -> both grants 0; the scoreboard bit set by the previous cycle's "mul x10" stays set.
REQ-036 Assert rst while div_busy=1 and scoreboard bits x7 and x9 are set -> div_busy=0, sb_busy=0, grants 0 immediately, asynchronously.
